// File: rtl/alu_arb_pkg.sv
// -----------------------------------------------------------------------------
// alu_arb_pkg
// Shared types and constants for the ALU arbiter slice:
//   - alu_arb_state_t : arbiter FSM states (IDLE / EXEC / RESP)
//   - ALU_CTRL_W      : width of the ALU control lines (4)
//   - ALU_* codes     : ALU control encodings understood by the shared ALU
//   - alu_arb_req_t   : latched request payload (ctrl, a, b)
// The payload struct carries operands at ALU_DATA_MAX_W bits so one package
// type serves every DATA_WIDTH up to that limit; users zero-extend into it and
// truncate out of it.
// -----------------------------------------------------------------------------
package alu_arb_pkg;

    localparam int ALU_CTRL_W     = 4;
    localparam int ALU_DATA_MAX_W = 64;

    localparam logic [ALU_CTRL_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [ALU_CTRL_W-1:0] ALU_NOR = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } alu_arb_state_t;

    typedef struct packed {
        logic [ALU_CTRL_W-1:0]     ctrl;
        logic [ALU_DATA_MAX_W-1:0] a;
        logic [ALU_DATA_MAX_W-1:0] b;
    } alu_arb_req_t;

endpackage

// File: rtl/alu_arb_grant.sv
// -----------------------------------------------------------------------------
// alu_arb_grant
// Combinational grant selection. Searches the valid vector starting at
// i_ptr+1 (modulo NUM_REQ) and returns the first valid requester as a one-hot
// grant plus its index. Feeding a constant i_ptr of NUM_REQ-1 turns this into
// a fixed lowest-index-wins priority encoder.
// Ports:
//   i_valid [NUM_REQ]  request valid vector
//   i_ptr   [IDX_W]    last granted index (search starts after it)
//   o_grant [NUM_REQ]  one-hot grant, zero when nothing is valid
//   o_idx   [IDX_W]    index of the granted requester (0 when none)
// -----------------------------------------------------------------------------
module alu_arb_grant
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx
);

    logic w_found;

    // Outer loop walks search positions in priority order; the inner loop
    // compares against constant indices so no variable bit-select is needed.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!w_found && i_valid[j] && (j == ((int'(i_ptr) + k) % NUM_REQ))) begin
                    w_found    = 1'b1;
                    o_grant[j] = 1'b1;
                    o_idx      = IDX_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one combinational ALU among NUM_REQ requesters. One operation is in
// flight at a time: IDLE (accept) -> EXEC (ALU evaluates latched operands,
// result captured) -> RESP (result held until the granted requester takes it).
// Configuration macro:
//   ALU_ARB_RR_EN  defined   -> round-robin selection, pointer advances on accept
//                  undefined -> fixed priority, lowest index wins
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_req_valid / o_req_ready    per-requester request handshake
//   i_req_ctrl, i_req_a, i_req_b per-requester ALU control and operands
//   o_rsp_valid / i_rsp_ready    per-requester response handshake
//   o_rsp_result, o_rsp_zero     captured ALU result and zero flag
//   o_alu_ctrl, o_alu_a, o_alu_b registered drive to the shared ALU
//   i_alu_result, i_alu_zero     shared ALU outputs
// DATA_WIDTH must not exceed ALU_DATA_MAX_W.
// -----------------------------------------------------------------------------
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 32
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic [NUM_REQ-1:0]                    i_req_valid,
    output logic [NUM_REQ-1:0]                    o_req_ready,
    input  logic [NUM_REQ-1:0][ALU_CTRL_W-1:0]    i_req_ctrl,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    i_req_a,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    i_req_b,
    output logic [NUM_REQ-1:0]                    o_rsp_valid,
    input  logic [NUM_REQ-1:0]                    i_rsp_ready,
    output logic [DATA_WIDTH-1:0]                 o_rsp_result,
    output logic                                  o_rsp_zero,
    output logic [ALU_CTRL_W-1:0]                 o_alu_ctrl,
    output logic [DATA_WIDTH-1:0]                 o_alu_a,
    output logic [DATA_WIDTH-1:0]                 o_alu_b,
    input  logic [DATA_WIDTH-1:0]                 i_alu_result,
    input  logic                                  i_alu_zero
);

    localparam int IDX_W = $clog2(NUM_REQ);

    alu_arb_state_t        r_state;
    alu_arb_state_t        w_next;
    alu_arb_req_t          r_payload;
    alu_arb_req_t          w_sel;
    logic [IDX_W-1:0]      r_gidx;
    logic [IDX_W-1:0]      w_ptr;
    logic [IDX_W-1:0]      w_idx;
    logic [NUM_REQ-1:0]    w_grant;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_zero;

`ifdef ALU_ARB_RR_EN
    logic [IDX_W-1:0] r_ptr;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= IDX_W'(NUM_REQ - 1);
        end else if (w_accept) begin
            r_ptr <= w_idx;
        end
    end

    assign w_ptr = r_ptr;
`else
    // Constant pointer: search always starts at index 0.
    assign w_ptr = IDX_W'(NUM_REQ - 1);
`endif

    alu_arb_grant #(
        .NUM_REQ (NUM_REQ)
    ) u_grant (
        .i_valid (i_req_valid),
        .i_ptr   (w_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Ready is gated by reset so nothing is offered while a reset is pending.
    always_comb begin
        w_next      = r_state;
        o_req_ready = '0;
        o_rsp_valid = '0;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!i_rst && (|i_req_valid)) begin
                    o_req_ready = w_grant;
                    w_accept    = 1'b1;
                    w_next      = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_next = ST_RESP;
            end
            ST_RESP: begin
                for (int j = 0; j < NUM_REQ; j++) begin
                    o_rsp_valid[j] = (r_gidx == IDX_W'(j));
                end
                // Only the granted requester's ready bit can complete.
                if (|(o_rsp_valid & i_rsp_ready)) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_sel      = '0;
        w_sel.ctrl = i_req_ctrl[w_idx];
        w_sel.a    = ALU_DATA_MAX_W'(i_req_a[w_idx]);
        w_sel.b    = ALU_DATA_MAX_W'(i_req_b[w_idx]);
    end

    // Accept stage: latch payload and grant index.
    // Execute stage: capture the ALU outputs for the response.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_payload <= '0;
            r_gidx    <= '0;
            r_result  <= '0;
            r_zero    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_payload <= w_sel;
                r_gidx    <= w_idx;
            end
            if (r_state == ST_EXEC) begin
                r_result <= i_alu_result;
                r_zero   <= i_alu_zero;
            end
        end
    end

    // ALU drive comes only from registers, so it holds between operations.
    assign o_alu_ctrl   = r_payload.ctrl;
    assign o_alu_a      = DATA_WIDTH'(r_payload.a);
    assign o_alu_b      = DATA_WIDTH'(r_payload.b);
    assign o_rsp_result = r_result;
    assign o_rsp_zero   = r_zero;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Self-checking bench for alu_arbiter (NUM_REQ=2, DATA_WIDTH=32). A small
// behavioural ALU answers the arbiter's ALU port. Expected responses are
// queued when a request is driven and popped when a response handshake
// completes. Honours ALU_ARB_RR_EN for the contention expectations.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    localparam int NR = 2;
    localparam int DW = 32;

    logic                          clk = 1'b0;
    logic                          rst;
    logic [NR-1:0]                 req_valid;
    logic [NR-1:0]                 req_ready;
    logic [NR-1:0][ALU_CTRL_W-1:0] req_ctrl;
    logic [NR-1:0][DW-1:0]         req_a;
    logic [NR-1:0][DW-1:0]         req_b;
    logic [NR-1:0]                 rsp_valid;
    logic [NR-1:0]                 rsp_ready;
    logic [DW-1:0]                 rsp_result;
    logic                          rsp_zero;
    logic [ALU_CTRL_W-1:0]         alu_ctrl;
    logic [DW-1:0]                 alu_a;
    logic [DW-1:0]                 alu_b;
    logic [DW-1:0]                 alu_res;
    logic                          alu_zero;

    always #5 clk = ~clk;

    alu_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_ctrl   (req_ctrl),
        .i_req_a      (req_a),
        .i_req_b      (req_b),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_result (rsp_result),
        .o_rsp_zero   (rsp_zero),
        .o_alu_ctrl   (alu_ctrl),
        .o_alu_a      (alu_a),
        .o_alu_b      (alu_b),
        .i_alu_result (alu_res),
        .i_alu_zero   (alu_zero)
    );

    // Shared combinational ALU seen by the arbiter.
    always_comb begin
        alu_res = '0;
        case (alu_ctrl)
            ALU_AND: alu_res = alu_a & alu_b;
            ALU_OR:  alu_res = alu_a | alu_b;
            ALU_ADD: alu_res = alu_a + alu_b;
            ALU_SUB: alu_res = alu_a - alu_b;
            ALU_SLT: alu_res = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            ALU_NOR: alu_res = ~(alu_a | alu_b);
            default: alu_res = '0;
        endcase
    end
    assign alu_zero = (alu_res == '0);

    typedef struct {
        int                    idx;
        logic [ALU_CTRL_W-1:0] ctrl;
        logic [DW-1:0]         a;
        logic [DW-1:0]         b;
        logic [DW-1:0]         res;
        logic                  zero;
    } vec_t;

    typedef struct {
        int            idx;
        logic [DW-1:0] res;
        logic          zero;
    } exp_t;

    exp_t sb[$];
    int   grant_log[$];
    int   n_vec = 0;
    int   n_err = 0;
    exp_t mon_e;
    logic [NR-1:0] mon_oh;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [NR-1:0] onehot(input int idx);
        logic [NR-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Response monitor / grant logger.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NR; i++) begin
                if (req_ready[i]) grant_log.push_back(i);
            end
            if (|(rsp_valid & rsp_ready)) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_rsp: rsp_valid=%b with nothing outstanding", rsp_valid);
                end else begin
                    mon_e  = sb.pop_front();
                    mon_oh = onehot(mon_e.idx);
                    check("rsp_valid_idx", 64'(rsp_valid), 64'(mon_oh));
                    check("rsp_result", 64'(rsp_result), 64'(mon_e.res));
                    check("rsp_zero", 64'(rsp_zero), 64'(mon_e.zero));
                end
            end
        end
    end

    task automatic wait_ready(input int idx);
        bit ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (req_ready[idx]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL ready_timeout: req_ready[%0d] never rose", idx);
        end
    endtask

    task automatic wait_rsp(input int idx);
        bit ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rsp_valid[idx]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL rsp_timeout: rsp_valid[%0d] never rose", idx);
        end
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 40 && sb.size() != 0; c++) @(negedge clk);
        check("sb_drain", 64'(sb.size()), 64'd0);
    endtask

    task automatic drive(input int idx, input logic [ALU_CTRL_W-1:0] c,
                         input logic [DW-1:0] a, input logic [DW-1:0] b);
        req_ctrl[idx]  = c;
        req_a[idx]     = a;
        req_b[idx]     = b;
        req_valid[idx] = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, "_rsp_result"}, 64'(rsp_result), 64'd0);
        check({tag, "_rsp_zero"}, 64'(rsp_zero), 64'd0);
        check({tag, "_alu_ctrl"}, 64'(alu_ctrl), 64'd0);
        check({tag, "_alu_a"}, 64'(alu_a), 64'd0);
        check({tag, "_alu_b"}, 64'(alu_b), 64'd0);
    endtask

    vec_t tbl[8];
    int   exp_g[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{0, ALU_ADD, 32'd5,          32'd7,          32'd12,         1'b0};
        tbl[1] = '{1, ALU_SUB, 32'd9,          32'd9,          32'd0,          1'b1};
        tbl[2] = '{0, ALU_AND, 32'h0000_f0f0,  32'h0000_ff00,  32'h0000_f000,  1'b0};
        tbl[3] = '{1, ALU_OR,  32'h0000_000f,  32'h0000_0000,  32'h0000_000f,  1'b0};
        tbl[4] = '{0, ALU_SLT, 32'hffff_ffff,  32'd1,          32'd1,          1'b0};
        tbl[5] = '{1, ALU_NOR, 32'd0,          32'd0,          32'hffff_ffff,  1'b0};
        tbl[6] = '{0, ALU_ADD, 32'hffff_ffff,  32'd1,          32'd0,          1'b1};
        tbl[7] = '{1, ALU_SUB, 32'd0,          32'd1,          32'hffff_ffff,  1'b0};

        rst       = 1'b1;
        req_valid = '0;
        req_ctrl  = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_no_req_ready", 64'(req_ready), 64'd0);

        // Table-driven single operations with immediate consume
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            sb.push_back('{idx: tbl[i].idx, res: tbl[i].res, zero: tbl[i].zero});
            rsp_ready[tbl[i].idx] = 1'b1;
            drive(tbl[i].idx, tbl[i].ctrl, tbl[i].a, tbl[i].b);
            wait_ready(tbl[i].idx);
            check("ready_onehot", 64'(req_ready), 64'(onehot(tbl[i].idx)));
            @(posedge clk); #1;
            req_valid[tbl[i].idx] = 1'b0;
            @(negedge clk);
            check("ready_pulse", 64'(req_ready), 64'd0);
            check("rsp_early", 64'(rsp_valid), 64'd0);
            @(negedge clk);
            check("rsp_latency", 64'(rsp_valid), 64'(onehot(tbl[i].idx)));
            @(posedge clk); #1;
            rsp_ready[tbl[i].idx] = 1'b0;
        end
        wait_drain();

        // Contention: both requesters held valid
        grant_log.delete();
`ifdef ALU_ARB_RR_EN
        exp_g = '{0, 1, 0, 1};
`else
        exp_g = '{0, 0, 0};
`endif
        foreach (exp_g[k]) sb.push_back('{idx: exp_g[k], res: (exp_g[k] == 0) ? 32'd3 : 32'd30, zero: 1'b0});
        @(posedge clk); #1;
        rsp_ready = '1;
        drive(0, ALU_ADD, 32'd1, 32'd2);
        drive(1, ALU_ADD, 32'd10, 32'd20);
        for (int c = 0; c < 40 && grant_log.size() < exp_g.size(); c++) @(negedge clk);
        @(posedge clk); #1;
        req_valid = '0;
        wait_drain();
        check("contention_count", 64'(grant_log.size()), 64'(exp_g.size()));
        for (int k = 0; k < exp_g.size() && k < grant_log.size(); k++) begin
            check("contention_order", 64'(grant_log[k]), 64'(exp_g[k]));
        end

        // Backpressure: rsp_ready[0] low for 5 cycles
        @(posedge clk); #1;
        rsp_ready = '0;
        sb.push_back('{idx: 0, res: 32'd123, zero: 1'b0});
        drive(0, ALU_ADD, 32'd100, 32'd23);
        wait_ready(0);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        sb.push_back('{idx: 1, res: 32'd42, zero: 1'b0});
        drive(1, ALU_SUB, 32'd50, 32'd8);
        rsp_ready[1] = 1'b1;
        wait_rsp(0);
        for (int c = 0; c < 5; c++) begin
            check("bp_rsp_valid", 64'(rsp_valid), 64'b01);
            check("bp_result", 64'(rsp_result), 64'd123);
            check("bp_req_ready", 64'(req_ready), 64'd0);
            if (c < 4) @(negedge clk);
        end
        @(posedge clk); #1;
        rsp_ready[0] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[0] = 1'b0;
        @(negedge clk);
        check("bp_next_accept", 64'(req_ready), 64'b10);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        wait_drain();

        // Reset while an operation is in EXEC
        @(posedge clk); #1;
        rsp_ready = '1;
        drive(0, ALU_ADD, 32'd7, 32'd8);
        wait_ready(0);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("midrst");
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("midrst_no_rsp", 64'(rsp_valid), 64'd0);
        end
        @(posedge clk); #1;
        sb.push_back('{idx: 0, res: 32'd5, zero: 1'b0});
        sb.push_back('{idx: 1, res: 32'h3c, zero: 1'b0});
        drive(0, ALU_ADD, 32'd2, 32'd3);
        drive(1, ALU_OR, 32'h30, 32'h0c);
        wait_ready(0);
        check("midrst_first_grant", 64'(req_ready), 64'b01);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        wait_ready(1);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        wait_drain();

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
